// File: rtl/demux_1an_rr_pkg.sv
// Shared constants for the round-robin lane demultiplexer and its pointer.
// IDLE_MAX is used only when DEMUX_IDLE_RESYNC_EN is defined.
package demux_1an_rr_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_LANES = 2;

  localparam logic MODE_SEL = 1'b0;
  localparam logic MODE_RR  = 1'b1;

  localparam int IDLE_MAX = 16;
  localparam int IDLE_W   = $clog2(IDLE_MAX + 1);

endpackage

// File: rtl/demux_rr_ptr.sv
// Round-robin lane pointer with wrap at LANES-1.
// Define DEMUX_IDLE_RESYNC_EN to return the pointer to lane 0 after IDLE_MAX idle cycles.
module demux_rr_ptr
  import demux_1an_rr_pkg::*;
#(
  parameter  int LANES = DEF_LANES,
  localparam int SEL_W = $clog2(LANES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_mode,
  input  logic             i_valid,
  output logic [SEL_W-1:0] o_ptr
);

  localparam logic [SEL_W-1:0] LAST = SEL_W'(LANES - 1);

  logic [SEL_W-1:0] r_ptr;
  logic [SEL_W-1:0] w_ptr_next;
  logic             w_adv;
  logic             w_resync;

  assign w_adv = i_valid && (i_mode == MODE_RR);

`ifdef DEMUX_IDLE_RESYNC_EN
  logic [IDLE_W-1:0] r_idle;
  logic [IDLE_W-1:0] w_idle_next;

  always_comb begin
    w_idle_next = r_idle;
    if (i_valid) begin
      w_idle_next = '0;
    end else if (r_idle != IDLE_W'(IDLE_MAX)) begin
      w_idle_next = r_idle + 1'b1;
    end
  end

  // Resync fires on the edge where the idle run reaches IDLE_MAX (and while saturated).
  assign w_resync = !i_valid && (w_idle_next == IDLE_W'(IDLE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle <= '0;
    end else begin
      r_idle <= w_idle_next;
    end
  end
`else
  assign w_resync = 1'b0;
`endif

  always_comb begin
    w_ptr_next = r_ptr;
    if (w_resync) begin
      w_ptr_next = '0;
    end else if (w_adv) begin
      w_ptr_next = (r_ptr == LAST) ? '0 : r_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr_next;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/demux_1an_rr.sv
// 1-to-LANES registered word demultiplexer: external select or round-robin steering.
// Optional idle pointer resync is enabled by defining DEMUX_IDLE_RESYNC_EN.
module demux_1an_rr
  import demux_1an_rr_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int LANES = DEF_LANES,
  localparam int SEL_W = $clog2(LANES)
) (
  input  logic                   clk_4f,
  input  logic                   reset_L,
  input  logic                   mode,
  input  logic [SEL_W-1:0]       selectorL,
  input  logic                   valid,
  input  logic [WIDTH-1:0]       data_in,
  output logic [LANES-1:0]       validout,
  output logic [LANES*WIDTH-1:0] dataout,
  output logic [SEL_W-1:0]       lane_ptr,
  output logic                   sel_err
);

  localparam logic [SEL_W:0] LANES_C = (SEL_W + 1)'(LANES);

  logic [SEL_W-1:0] w_ptr;
  logic [SEL_W-1:0] w_target;
  logic             w_in_range;
  logic             w_hit;
  logic [LANES-1:0] w_lane_hit;
  logic [LANES-1:0] r_validout;
  logic [WIDTH-1:0] r_data [LANES];
  logic             r_sel_err;

  demux_rr_ptr #(
    .LANES (LANES)
  ) u_ptr (
    .clk     (clk_4f),
    .rst_n   (reset_L),
    .i_mode  (mode),
    .i_valid (valid),
    .o_ptr   (w_ptr)
  );

  assign w_target   = (mode == MODE_RR) ? w_ptr : selectorL;
  assign w_in_range = ({1'b0, w_target} < LANES_C);
  assign w_hit      = valid && w_in_range;

  // Non-target lanes keep their last word; only the hit lane loads.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_lane_hit[gi] = w_hit && (w_target == SEL_W'(gi));

    always_ff @(posedge clk_4f or negedge reset_L) begin
      if (!reset_L) begin
        r_data[gi] <= '0;
      end else if (w_lane_hit[gi]) begin
        r_data[gi] <= data_in;
      end
    end

    assign dataout[gi*WIDTH +: WIDTH] = r_data[gi];
  end

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_validout <= '0;
      r_sel_err  <= 1'b0;
    end else begin
      r_validout <= w_lane_hit;
      r_sel_err  <= valid && !w_in_range;
    end
  end

  assign validout = r_validout;
  assign lane_ptr = w_ptr;
  assign sel_err  = r_sel_err;

endmodule

// File: tb/tb_demux_1an_rr.sv
// Directed self-checking bench for demux_1an_rr with LANES = 2, 3 and 4 instances.
// The idle-resync expectations follow whether DEMUX_IDLE_RESYNC_EN is defined.
module tb_demux_1an_rr;

  logic clk_4f = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk_4f = ~clk_4f;

  int checks = 0;
  int failures = 0;

  // LANES = 2 instance
  logic       a_mode = 1'b0, a_valid = 1'b0;
  logic [0:0] a_sel = '0;
  logic [7:0] a_din = '0;
  logic [1:0] a_vo;
  logic [15:0] a_dout;
  logic [0:0] a_ptr;
  logic       a_err;

  // LANES = 3 instance
  logic       b_mode = 1'b0, b_valid = 1'b0;
  logic [1:0] b_sel = '0;
  logic [7:0] b_din = '0;
  logic [2:0] b_vo;
  logic [23:0] b_dout;
  logic [1:0] b_ptr;
  logic       b_err;

  // LANES = 4 instance
  logic       c_mode = 1'b0, c_valid = 1'b0;
  logic [1:0] c_sel = '0;
  logic [7:0] c_din = '0;
  logic [3:0] c_vo;
  logic [31:0] c_dout;
  logic [1:0] c_ptr;
  logic       c_err;

  demux_1an_rr #(.WIDTH(8), .LANES(2)) u_dut2 (
    .clk_4f(clk_4f), .reset_L(reset_L), .mode(a_mode), .selectorL(a_sel),
    .valid(a_valid), .data_in(a_din), .validout(a_vo), .dataout(a_dout),
    .lane_ptr(a_ptr), .sel_err(a_err)
  );

  demux_1an_rr #(.WIDTH(8), .LANES(3)) u_dut3 (
    .clk_4f(clk_4f), .reset_L(reset_L), .mode(b_mode), .selectorL(b_sel),
    .valid(b_valid), .data_in(b_din), .validout(b_vo), .dataout(b_dout),
    .lane_ptr(b_ptr), .sel_err(b_err)
  );

  demux_1an_rr #(.WIDTH(8), .LANES(4)) u_dut4 (
    .clk_4f(clk_4f), .reset_L(reset_L), .mode(c_mode), .selectorL(c_sel),
    .valid(c_valid), .data_in(c_din), .validout(c_vo), .dataout(c_dout),
    .lane_ptr(c_ptr), .sel_err(c_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk_4f);
    #1;
  endtask

  initial begin
    reset_L = 1'b0;
    repeat (2) step();
    check_val("rst_vo2",   64'(a_vo),   64'h0);
    check_val("rst_dout2", 64'(a_dout), 64'h0);
    check_val("rst_ptr2",  64'(a_ptr),  64'h0);
    check_val("rst_err2",  64'(a_err),  64'h0);
    check_val("rst_dout3", 64'(b_dout), 64'h0);
    @(negedge clk_4f);
    reset_L = 1'b1;
    step();

    // LANES=2 round robin A1, B2, C3
    a_mode = 1'b1; a_valid = 1'b1; a_din = 8'hA1;
    step();
    check_val("rr2_w0_vo",  64'(a_vo),         64'h1);
    check_val("rr2_w0_l0",  64'(a_dout[7:0]),  64'hA1);
    check_val("rr2_w0_ptr", 64'(a_ptr),        64'h1);
    a_din = 8'hB2;
    step();
    check_val("rr2_w1_vo",  64'(a_vo),         64'h2);
    check_val("rr2_w1_l1",  64'(a_dout[15:8]), 64'hB2);
    check_val("rr2_w1_ptr", 64'(a_ptr),        64'h0);
    a_din = 8'hC3;
    step();
    check_val("rr2_w2_vo",  64'(a_vo),         64'h1);
    check_val("rr2_w2_dout",64'(a_dout),       64'hB2C3);
    check_val("rr2_w2_ptr", 64'(a_ptr),        64'h1);
    a_valid = 1'b0;
    step();
    check_val("idle2_vo",   64'(a_vo),   64'h0);
    check_val("idle2_dout", 64'(a_dout), 64'hB2C3);
    check_val("idle2_ptr",  64'(a_ptr),  64'h1);

    // Mode switch with lane_ptr = 1
    a_mode = 1'b0; a_sel = 1'b0; a_valid = 1'b1; a_din = 8'h77;
    step();
    check_val("sw_sel_vo",   64'(a_vo),   64'h1);
    check_val("sw_sel_dout", 64'(a_dout), 64'hB277);
    check_val("sw_sel_ptr",  64'(a_ptr),  64'h1);
    a_mode = 1'b1; a_din = 8'h88;
    step();
    check_val("sw_rr_vo",   64'(a_vo),   64'h2);
    check_val("sw_rr_dout", 64'(a_dout), 64'h8877);
    check_val("sw_rr_ptr",  64'(a_ptr),  64'h0);
    a_valid = 1'b0;

    // LANES=3 out-of-range selector
    b_mode = 1'b0; b_sel = 2'd3; b_valid = 1'b1; b_din = 8'h55;
    step();
    check_val("oor_vo",   64'(b_vo),   64'h0);
    check_val("oor_err",  64'(b_err),  64'h1);
    check_val("oor_dout", 64'(b_dout), 64'h0);
    b_valid = 1'b0;
    step();
    check_val("oor_err_clr", 64'(b_err), 64'h0);
    b_sel = 2'd2; b_valid = 1'b1; b_din = 8'h5A;
    step();
    check_val("sel2_vo",   64'(b_vo),   64'h4);
    check_val("sel2_dout", 64'(b_dout), 64'h5A0000);
    check_val("sel2_err",  64'(b_err),  64'h0);
    check_val("sel2_ptr",  64'(b_ptr),  64'h0);

    // LANES=3 round robin with a gap: 1,0,1,1
    b_mode = 1'b1; b_valid = 1'b1; b_din = 8'h10;
    step();
    check_val("rr3_a_vo",  64'(b_vo),  64'h1);
    check_val("rr3_a_ptr", 64'(b_ptr), 64'h1);
    b_valid = 1'b0; b_din = 8'hEE;
    step();
    check_val("rr3_gap_vo",  64'(b_vo),  64'h0);
    check_val("rr3_gap_ptr", 64'(b_ptr), 64'h1);
    b_valid = 1'b1; b_din = 8'h20;
    step();
    check_val("rr3_b_vo",  64'(b_vo),  64'h2);
    check_val("rr3_b_ptr", 64'(b_ptr), 64'h2);
    b_din = 8'h30;
    step();
    check_val("rr3_c_vo",   64'(b_vo),   64'h4);
    check_val("rr3_c_dout", 64'(b_dout), 64'h302010);
    check_val("rr3_c_ptr",  64'(b_ptr),  64'h0);
    b_valid = 1'b0;

    // LANES=4 idle resync: bring pointer to 2, then 16 idle cycles
    c_mode = 1'b1; c_valid = 1'b1; c_din = 8'h01;
    step();
    c_din = 8'h02;
    step();
    check_val("idl_pre_ptr", 64'(c_ptr), 64'h2);
    c_valid = 1'b0;
    repeat (15) step();
    check_val("idl_15_ptr", 64'(c_ptr), 64'h2);
    step();
`ifdef DEMUX_IDLE_RESYNC_EN
    check_val("idl_16_ptr", 64'(c_ptr), 64'h0);
`else
    check_val("idl_16_ptr", 64'(c_ptr), 64'h2);
`endif
    c_valid = 1'b1; c_din = 8'h99;
    step();
`ifdef DEMUX_IDLE_RESYNC_EN
    check_val("idl_99_vo",   64'(c_vo),   64'h1);
    check_val("idl_99_dout", 64'(c_dout), 64'h00000299);
    check_val("idl_99_ptr",  64'(c_ptr),  64'h1);
`else
    check_val("idl_99_vo",   64'(c_vo),   64'h4);
    check_val("idl_99_dout", 64'(c_dout), 64'h00990201);
    check_val("idl_99_ptr",  64'(c_ptr),  64'h3);
`endif
    c_valid = 1'b0;

    // Mid-stream async reset between edges, with a word in flight on LANES=2
    a_mode = 1'b1; a_valid = 1'b1; a_din = 8'h3C;
    step();
    check_val("pre_rst_vo",  64'(a_vo),  64'h1);
    check_val("pre_rst_ptr", 64'(a_ptr), 64'h1);
    #2;
    reset_L = 1'b0;
    #1;
    check_val("async_vo2",   64'(a_vo),   64'h0);
    check_val("async_dout2", 64'(a_dout), 64'h0);
    check_val("async_ptr2",  64'(a_ptr),  64'h0);
    check_val("async_dout3", 64'(b_dout), 64'h0);
    check_val("async_vo4",   64'(c_vo),   64'h0);
    a_valid = 1'b0;
    @(negedge clk_4f);
    reset_L = 1'b1;
    step();
    check_val("post_rst_ptr2", 64'(a_ptr), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
